// File: rtl/ppfifo_sink_if.sv
// ppfifo_sink_if: read-port handshake between a Ping Pong FIFO and its reader.
//   i_rd_rdy   FIFO -> reader  a filled buffer is available
//   o_rd_act   reader -> FIFO  buffer is owned by the reader
//   i_rd_size  FIFO -> reader  word count of the offered buffer
//   o_rd_stb   reader -> FIFO  consume current word (FIFO advances after the edge)
//   i_rd_data  FIFO -> reader  current FIFO word
// Modports: master = reader side (ppfifo_sink), slave = FIFO side.
interface ppfifo_sink_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_rd_rdy;
  logic                  o_rd_act;
  logic [23:0]           i_rd_size;
  logic                  o_rd_stb;
  logic [DATA_WIDTH-1:0] i_rd_data;

  modport master (
    input  i_rd_rdy,
    input  i_rd_size,
    input  i_rd_data,
    output o_rd_act,
    output o_rd_stb
  );

  modport slave (
    output i_rd_rdy,
    output i_rd_size,
    output i_rd_data,
    input  o_rd_act,
    input  o_rd_stb
  );
endinterface

// File: rtl/ppfifo_sink.sv
// ppfifo_sink: reader for the read side of the Ping Pong FIFO. Acquires a
// filled buffer, strobes out every word, checks word k against k (truncated
// to DATA_WIDTH), releases the buffer and keeps pass/fail statistics.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_enable          permits acquiring a new buffer (never aborts one)
//   i_clear           one-cycle pulse, zeroes all statistics outputs
//   rd                FIFO read handshake (ppfifo_sink_if.master)
//   o_error           sticky mismatch flag
//   o_error_count     saturating mismatch count
//   o_packet_count    completed buffers, wrapping
//   o_err_index       word index of the first mismatch
//   o_err_expected    expected value at the first mismatch
//   o_err_actual      received value at the first mismatch
module ppfifo_sink #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_enable,
  input  logic                  i_clear,
  ppfifo_sink_if.master         rd,
  output logic                  o_error,
  output logic [15:0]           o_error_count,
  output logic [31:0]           o_packet_count,
  output logic [23:0]           o_err_index,
  output logic [DATA_WIDTH-1:0] o_err_expected,
  output logic [DATA_WIDTH-1:0] o_err_actual
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t      state_r;
  logic [23:0] r_size;
  logic [23:0] r_issued;
  logic [23:0] r_expected;

  logic acquire_s;
  logic done_s;
  logic mismatch_s;

  // Decode acquisition, buffer completion and word mismatch for this cycle.
  always_comb begin
    acquire_s  = 1'b0;
    done_s     = 1'b0;
    mismatch_s = 1'b0;
    case (state_r)
      IDLE: begin
        acquire_s = i_enable & rd.i_rd_rdy & ~rd.o_rd_act;
      end
      ACTIVE: begin
        done_s = (r_issued == r_size);
      end
      default: begin
        acquire_s = 1'b0;
        done_s    = 1'b0;
      end
    endcase
    // The word on i_rd_data is consumed at the edge that ends a strobe cycle.
    if (rd.o_rd_stb) begin
      mismatch_s = (rd.i_rd_data != r_expected[DATA_WIDTH-1:0]);
    end else begin
      mismatch_s = 1'b0;
    end
  end

  // Buffer ownership FSM with registered act/strobe outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rd.o_rd_act <= 1'b0;
      rd.o_rd_stb <= 1'b0;
      r_size      <= 24'd0;
      r_issued    <= 24'd0;
    end else begin
      case (state_r)
        IDLE: begin
          rd.o_rd_stb <= 1'b0;
          if (acquire_s) begin
            rd.o_rd_act <= 1'b1;
            r_size      <= rd.i_rd_size;
            r_issued    <= 24'd0;
            state_r     <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (done_s) begin
            // Release: the final compare happens at this same edge.
            rd.o_rd_stb <= 1'b0;
            rd.o_rd_act <= 1'b0;
            state_r     <= IDLE;
          end else begin
            rd.o_rd_stb <= 1'b1;
            r_issued    <= r_issued + 24'd1;
          end
        end
        default: begin
          rd.o_rd_stb <= 1'b0;
          rd.o_rd_act <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  // Expected-pattern counter: restarts on acquisition, steps on every consumed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_expected <= 24'd0;
    end else if (acquire_s) begin
      r_expected <= 24'd0;
    end else if (rd.o_rd_stb) begin
      r_expected <= r_expected + 24'd1;
    end else begin
      r_expected <= r_expected;
    end
  end

  // Statistics; a clear pulse overrides any mismatch or completion in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_error        <= 1'b0;
      o_error_count  <= 16'd0;
      o_packet_count <= 32'd0;
      o_err_index    <= 24'd0;
      o_err_expected <= '0;
      o_err_actual   <= '0;
    end else if (i_clear) begin
      o_error        <= 1'b0;
      o_error_count  <= 16'd0;
      o_packet_count <= 32'd0;
      o_err_index    <= 24'd0;
      o_err_expected <= '0;
      o_err_actual   <= '0;
    end else begin
      if (mismatch_s) begin
        o_error <= 1'b1;
        if (o_error_count != 16'hFFFF) begin
          o_error_count <= o_error_count + 16'd1;
        end
        // Only the first mismatch since reset/clear is captured.
        if (!o_error) begin
          o_err_index    <= r_expected;
          o_err_expected <= r_expected[DATA_WIDTH-1:0];
          o_err_actual   <= rd.i_rd_data;
        end
      end
      if (done_s) begin
        o_packet_count <= o_packet_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ppfifo_sink.sv
// tb_ppfifo_sink: directed and randomized checks of ppfifo_sink. The bench
// plays the FIFO (offers buffers, advances data after each strobe) and keeps
// a word-level reference of the expected statistics.
module tb_ppfifo_sink;

  logic clk = 1'b0;
  logic rst_n;
  logic i_enable;
  logic i_clear;
  logic        o_error;
  logic [15:0] o_error_count;
  logic [31:0] o_packet_count;
  logic [23:0] o_err_index;
  logic [7:0]  o_err_expected;
  logic [7:0]  o_err_actual;

  ppfifo_sink_if #(.DATA_WIDTH(8)) rd_if ();

  ppfifo_sink #(.DATA_WIDTH(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_enable       (i_enable),
    .i_clear        (i_clear),
    .rd             (rd_if),
    .o_error        (o_error),
    .o_error_count  (o_error_count),
    .o_packet_count (o_packet_count),
    .o_err_index    (o_err_index),
    .o_err_expected (o_err_expected),
    .o_err_actual   (o_err_actual)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference statistics
  bit          m_err;
  int          m_cnt;
  logic [31:0] m_pkts;
  logic [23:0] m_idx;
  logic [7:0]  m_exp;
  logic [7:0]  m_act;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    m_err = 1'b0; m_cnt = 0; m_pkts = 32'd0;
    m_idx = 24'd0; m_exp = 8'd0; m_act = 8'd0;
  endtask

  task automatic model_word(input int k, input logic [7:0] v);
    if (v != 8'(k)) begin
      if (!m_err) begin
        m_idx = 24'(k); m_exp = 8'(k); m_act = v;
      end
      m_err = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic check_stats(input string tag);
    chk({tag, ".error"},  32'(o_error),        32'(m_err));
    chk({tag, ".ecnt"},   32'(o_error_count),  32'(m_cnt));
    chk({tag, ".pkts"},   o_packet_count,      m_pkts);
    chk({tag, ".eidx"},   32'(o_err_index),    32'(m_idx));
    chk({tag, ".eexp"},   32'(o_err_expected), 32'(m_exp));
    chk({tag, ".eact"},   32'(o_err_actual),   32'(m_act));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".act"}, 32'(rd_if.o_rd_act), 32'd0);
    chk({tag, ".stb"}, 32'(rd_if.o_rd_stb), 32'd0);
    check_stats(tag);
  endtask

  // One buffer as seen by the FIFO. Words are k mod 256 except bad_k.
  // drop_en_k / clr_k / rst_k: strobe index at which enable falls, clear
  // pulses, or reset is asserted (-1 = never).
  task automatic run_buffer(input string tag, input int size, input int bad_k,
                            input logic [7:0] bad_v, input int drop_en_k,
                            input int clr_k, input int rst_k);
    logic [7:0] dat [$];
    int  ptr = 0, act_cyc = 0, stb_cyc = 0, budget;
    bit  seen_act = 0, done = 0, gap = 0, aborted = 0, prev_stb = 0;
    for (int k = 0; k < size; k++) dat.push_back((k == bad_k) ? bad_v : 8'(k));
    @(negedge clk);
    rd_if.i_rd_size = 24'(size);
    rd_if.i_rd_rdy  = 1'b1;
    budget = size + 30;
    while (!done && budget > 0) begin
      @(negedge clk);
      budget--;
      i_clear = 1'b0;
      if (rd_if.o_rd_act) begin
        act_cyc++; seen_act = 1; rd_if.i_rd_rdy = 1'b0;
      end else if (seen_act) begin
        done = 1;
      end
      if (rd_if.o_rd_stb && !done) begin
        if (stb_cyc > 0 && !prev_stb) gap = 1;
        stb_cyc++;
        if (ptr < size) rd_if.i_rd_data = dat[ptr];
        if (ptr == clr_k) begin
          i_clear = 1'b1;
          model_zero();
        end else if (ptr < size) begin
          model_word(ptr, dat[ptr]);
        end
        if (ptr == drop_en_k) i_enable = 1'b0;
        if (ptr == rst_k) begin
          #1 rst_n = 1'b0;
          #1;
          model_zero();
          check_all_zero({tag, ".rst"});
          rd_if.i_rd_rdy = 1'b0;
          aborted = 1; done = 1;
        end
        ptr++;
      end
      prev_stb = rd_if.o_rd_stb;
    end
    chk({tag, ".finished"}, 32'(done), 32'd1);
    if (!aborted) begin
      if (clr_k < 0 || clr_k != size - 1) m_pkts = m_pkts + 32'd1;
      chk({tag, ".act_cycles"}, 32'(act_cyc), 32'(size + 1));
      chk({tag, ".strobes"},    32'(stb_cyc), 32'(size));
      chk({tag, ".stb_gap"},    32'(gap),     32'd0);
      @(negedge clk);
      @(negedge clk);
      check_stats(tag);
    end
  endtask

  initial begin
    rst_n = 1'b0; i_enable = 1'b0; i_clear = 1'b0;
    rd_if.i_rd_rdy = 1'b0; rd_if.i_rd_size = 24'd0; rd_if.i_rd_data = 8'd0;
    model_zero();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    i_enable = 1'b1;

    // clean and corrupted size-4 buffers
    run_buffer("good4", 4, -1, 8'd0, -1, -1, -1);
    run_buffer("bad4a", 4, 2, 8'd7, -1, -1, -1);
    chk("cap.idx", 32'(o_err_index), 32'd2);
    chk("cap.exp", 32'(o_err_expected), 32'd2);
    chk("cap.act", 32'(o_err_actual), 32'd7);
    run_buffer("bad4b", 4, 1, 8'h55, -1, -1, -1);
    chk("cap2.cnt", 32'(o_error_count), 32'd2);
    chk("cap2.idx", 32'(o_err_index), 32'd2);

    // clear, then size 0 followed by size 3
    @(negedge clk); i_clear = 1'b1;
    @(negedge clk); i_clear = 1'b0;
    model_zero();
    check_stats("clear");
    run_buffer("size0", 0, -1, 8'd0, -1, -1, -1);
    run_buffer("size3", 3, -1, 8'd0, -1, -1, -1);
    chk("pkts2", o_packet_count, 32'd2);

    // expected value wraps 255 -> 0 inside one buffer
    run_buffer("wrap300", 300, -1, 8'd0, -1, -1, -1);

    // reset during strobe 5, then a clean buffer after release
    run_buffer("rstmid", 10, -1, 8'd0, -1, -1, 4);
    @(negedge clk); rst_n = 1'b1;
    run_buffer("after_rst", 10, -1, 8'd0, -1, -1, -1);

    // enable falls at strobe 2: buffer completes, no reacquire until enabled
    run_buffer("en_drop", 6, -1, 8'd0, 1, -1, -1);
    rd_if.i_rd_size = 24'd2;
    rd_if.i_rd_rdy  = 1'b1;
    begin
      int act_seen = 0;
      repeat (6) begin
        @(negedge clk);
        if (rd_if.o_rd_act) act_seen++;
      end
      chk("no_reacquire", 32'(act_seen), 32'd0);
    end
    rd_if.i_rd_rdy = 1'b0;
    i_enable = 1'b1;
    run_buffer("reenable", 6, -1, 8'd0, -1, -1, -1);

    // clear coincident with a mismatch
    run_buffer("clr_mis", 4, 2, 8'd7, -1, 2, -1);
    chk("clr_mis.err0", 32'(o_error), 32'd0);
    chk("clr_mis.cnt0", 32'(o_error_count), 32'd0);

    // randomized buffers with occasional corrupted words
    for (int i = 0; i < 8; i++) begin
      int sz, bk;
      logic [7:0] bv;
      sz = int'($urandom_range(1, 40));
      bk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, sz - 1)) : -1;
      bv = 8'(bk) ^ 8'($urandom_range(1, 255));
      run_buffer($sformatf("rnd%0d", i), sz, bk, bv, -1, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
